// File: rtl/video_timing_gen.sv
// Raster timing generator: pixel enable, h/v counters, blank/sync strobes and line/frame pulses on sys_clk.
// Mode inputs (pal/scandouble) are sampled only at frame end so the downstream scaler never sees a torn frame.
module video_timing_gen #(
    parameter int CW            = 10,
    parameter int FRAME_W       = 8,
    parameter int PIX_DIV       = 2,
    parameter int H_TOTAL       = 638,
    parameter int H_BLANK_START = 529,
    parameter int H_SYNC_START  = 544,
    parameter int H_SYNC_END    = 590,
    parameter int V_TOTAL_N     = 262,
    parameter int V_BLANK_N     = 240,
    parameter int V_SYNC_N      = 245,
    parameter int V_SYNC_END_N  = 248,
    parameter int V_TOTAL_P     = 312,
    parameter int V_BLANK_P     = 300,
    parameter int V_SYNC_P      = 304,
    parameter int V_SYNC_END_P  = 308,
    parameter int HS_POL        = 1,
    parameter int VS_POL        = 1
) (
    input  logic               sys_clk,
    input  logic               RESn,
    input  logic               pal,
    input  logic               scandouble,
    output logic               ce_pix,
    output logic [CW-1:0]      hc,
    output logic [CW-1:0]      vc,
    output logic               HBlank,
    output logic               HSync,
    output logic               VBlank,
    output logic               VSync,
    output logic               de,
    output logic               line_start,
    output logic               frame_start,
    output logic [FRAME_W-1:0] frame_cnt,
    output logic               pal_act,
    output logic               sd_act
);
    localparam int DW = $clog2(PIX_DIV);

    localparam logic [DW-1:0] DIV_LAST = DW'(PIX_DIV - 1);
    localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
    localparam logic [CW-1:0] H_BS     = CW'(H_BLANK_START);
    localparam logic [CW-1:0] H_SS     = CW'(H_SYNC_START);
    localparam logic [CW-1:0] H_SE     = CW'(H_SYNC_END);
    localparam logic          HS_INACT = (HS_POL == 0);
    localparam logic          VS_INACT = (VS_POL == 0);

    logic [DW-1:0] div;
    logic          hsync_i;
    logic          vsync_i;
    logic [CW-1:0] vt;
    logic [CW-1:0] vb;
    logic [CW-1:0] vs;
    logic [CW-1:0] ve;
    logic [CW-1:0] vt_last;
    logic          line_end;
    logic          frame_end;

    // Vertical geometry of the mode currently in effect; doubled-rate modes double every line number.
    always_comb begin
        vt = pal_act ? CW'(V_TOTAL_P)    : CW'(V_TOTAL_N);
        vb = pal_act ? CW'(V_BLANK_P)    : CW'(V_BLANK_N);
        vs = pal_act ? CW'(V_SYNC_P)     : CW'(V_SYNC_N);
        ve = pal_act ? CW'(V_SYNC_END_P) : CW'(V_SYNC_END_N);
        if (sd_act) begin
            vt = vt << 1;
            vb = vb << 1;
            vs = vs << 1;
            ve = ve << 1;
        end
        vt_last = vt - CW'(1);
    end

    assign line_end  = ce_pix && (hc == H_LAST);
    assign frame_end = line_end && (vc == vt_last);

    always_ff @(posedge sys_clk or negedge RESn) begin
        if (!RESn) begin
            div    <= '0;
            ce_pix <= 1'b0;
            hc     <= '0;
            vc     <= '0;
        end else begin
            if (sd_act) begin
                div    <= '0;
                ce_pix <= 1'b1;
            end else begin
                ce_pix <= (div == DIV_LAST);
                div    <= (div == DIV_LAST) ? '0 : div + DW'(1);
            end
            if (ce_pix) begin
                if (hc == H_LAST) begin
                    hc <= '0;
                    vc <= (vc == vt_last) ? '0 : vc + CW'(1);
                end else begin
                    hc <= hc + CW'(1);
                end
            end
        end
    end

    // Strobes run on every sys_clk so they lag the counter condition by exactly one clock.
    always_ff @(posedge sys_clk or negedge RESn) begin
        if (!RESn) begin
            HBlank  <= 1'b0;
            hsync_i <= 1'b0;
            VBlank  <= 1'b0;
            vsync_i <= 1'b0;
        end else begin
            if (hc == H_BS)
                HBlank <= 1'b1;
            else if (hc == '0)
                HBlank <= 1'b0;
            if (hc == H_SS)
                hsync_i <= 1'b1;
            else if (hc == H_SE)
                hsync_i <= 1'b0;
            if (hc == H_SS) begin
                if (vc == vb)
                    VBlank <= 1'b1;
                else if (vc == '0)
                    VBlank <= 1'b0;
                if (vc == vs)
                    vsync_i <= 1'b1;
                else if (vc == ve)
                    vsync_i <= 1'b0;
            end
        end
    end

    always_ff @(posedge sys_clk or negedge RESn) begin
        if (!RESn) begin
            line_start  <= 1'b0;
            frame_start <= 1'b0;
            frame_cnt   <= '0;
            pal_act     <= 1'b0;
            sd_act      <= 1'b0;
        end else begin
            line_start  <= line_end;
            frame_start <= frame_end;
            if (frame_end) begin
                pal_act   <= pal;
                sd_act    <= scandouble;
                frame_cnt <= frame_cnt + FRAME_W'(1);
            end
        end
    end

    assign HSync = hsync_i ^ HS_INACT;
    assign VSync = vsync_i ^ VS_INACT;
    assign de    = ~HBlank & ~VBlank;

endmodule
